// File: rtl/frame_validator.sv
// frame_validator: checks decoded thermostat frames and publishes valid ones over a valid/ready handshake
// Ports: clk, rst_n (async active-low); full (frame-complete level, rising edge = new frame);
//   preamble/constant/thermostat_id/room_temp/set_temp/state/tail_1..3 (decoded fields);
//   out_valid/out_ready (publish handshake); *_out (last valid frame);
//   ok_count/err_count/drop_count (saturating); last_error (last checked frame failed).
// Optional feature: define FRAME_VALIDATOR_TAIL_CHECK_EN to require all tail bytes == EXPECTED_TAIL.
module frame_validator #(
  parameter logic [31:0] EXPECTED_PREAMBLE = 32'hAAAA_AAAA,
  parameter logic [31:0] EXPECTED_CONSTANT = 32'h0000_0000,
  parameter logic [7:0]  EXPECTED_TAIL     = 8'hFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        full,
  input  logic [31:0] preamble,
  input  logic [31:0] constant,
  input  logic [31:0] thermostat_id,
  input  logic [15:0] room_temp,
  input  logic [15:0] set_temp,
  input  logic [7:0]  state,
  input  logic [7:0]  tail_1,
  input  logic [7:0]  tail_2,
  input  logic [7:0]  tail_3,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] room_temp_out,
  output logic [15:0] set_temp_out,
  output logic [7:0]  state_out,
  output logic [31:0] thermostat_id_out,
  output logic [7:0]  ok_count,
  output logic [7:0]  err_count,
  output logic [3:0]  drop_count,
  output logic        last_error
);
  typedef enum logic [1:0] {IDLE, CHECK, PUBLISH} fsm_t;
  fsm_t fsm, fsm_nx;
  logic        full_q, strobe, frame_ok;
  logic [31:0] snap_pre, snap_con, snap_id;
  logic [15:0] snap_room, snap_set;
  logic [7:0]  snap_state;
  assign strobe    = full && !full_q;
  assign out_valid = fsm == PUBLISH;
`ifdef FRAME_VALIDATOR_TAIL_CHECK_EN
  logic [7:0] snap_t1, snap_t2, snap_t3;
  assign frame_ok = snap_pre == EXPECTED_PREAMBLE && snap_con == EXPECTED_CONSTANT &&
                    snap_t1 == EXPECTED_TAIL && snap_t2 == EXPECTED_TAIL && snap_t3 == EXPECTED_TAIL;
`else
  logic unused_tails;
  assign unused_tails = ^{tail_1, tail_2, tail_3};
  assign frame_ok = snap_pre == EXPECTED_PREAMBLE && snap_con == EXPECTED_CONSTANT;
`endif
  always_comb begin
    fsm_nx = fsm;
    case (fsm)
      IDLE:    fsm_nx = strobe ? CHECK : IDLE;
      CHECK:   fsm_nx = frame_ok ? PUBLISH : IDLE;
      PUBLISH: fsm_nx = out_ready ? IDLE : PUBLISH;
      default: fsm_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) fsm <= IDLE;
    else fsm <= fsm_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      full_q            <= 1'b0;
      snap_pre          <= '0;
      snap_con          <= '0;
      snap_id           <= '0;
      snap_room         <= '0;
      snap_set          <= '0;
      snap_state        <= '0;
`ifdef FRAME_VALIDATOR_TAIL_CHECK_EN
      snap_t1           <= '0;
      snap_t2           <= '0;
      snap_t3           <= '0;
`endif
      room_temp_out     <= '0;
      set_temp_out      <= '0;
      state_out         <= '0;
      thermostat_id_out <= '0;
      ok_count          <= '0;
      err_count         <= '0;
      drop_count        <= '0;
      last_error        <= 1'b0;
    end else begin
      full_q <= full;
      if (fsm == IDLE && strobe) begin
        snap_pre   <= preamble;
        snap_con   <= constant;
        snap_id    <= thermostat_id;
        snap_room  <= room_temp;
        snap_set   <= set_temp;
        snap_state <= state;
`ifdef FRAME_VALIDATOR_TAIL_CHECK_EN
        snap_t1    <= tail_1;
        snap_t2    <= tail_2;
        snap_t3    <= tail_3;
`endif
      end
      if (fsm != IDLE && strobe) drop_count <= drop_count + {3'd0, drop_count != 4'hF};
      if (fsm == CHECK) begin
        last_error <= !frame_ok;
        if (frame_ok) begin
          room_temp_out     <= snap_room;
          set_temp_out      <= snap_set;
          state_out         <= snap_state;
          thermostat_id_out <= snap_id;
          ok_count          <= ok_count + {7'd0, ok_count != 8'hFF};
        end else err_count <= err_count + {7'd0, err_count != 8'hFF};
      end
    end
endmodule

// File: tb/tb_frame_validator.sv
// tb_frame_validator: directed self-checking bench for frame_validator
module tb_frame_validator;
  logic        clk = 0, rst_n = 0, full = 0, out_ready = 0;
  logic [31:0] preamble, constant, thermostat_id;
  logic [15:0] room_temp, set_temp;
  logic [7:0]  state, tail_1, tail_2, tail_3;
  logic        out_valid, last_error;
  logic [15:0] room_temp_out, set_temp_out;
  logic [7:0]  state_out, ok_count, err_count;
  logic [31:0] thermostat_id_out;
  logic [3:0]  drop_count;
  int checks = 0, failures = 0;
  frame_validator dut (
    .clk(clk), .rst_n(rst_n), .full(full), .preamble(preamble), .constant(constant),
    .thermostat_id(thermostat_id), .room_temp(room_temp), .set_temp(set_temp), .state(state),
    .tail_1(tail_1), .tail_2(tail_2), .tail_3(tail_3), .out_valid(out_valid), .out_ready(out_ready),
    .room_temp_out(room_temp_out), .set_temp_out(set_temp_out), .state_out(state_out),
    .thermostat_id_out(thermostat_id_out), .ok_count(ok_count), .err_count(err_count),
    .drop_count(drop_count), .last_error(last_error)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic set_frame(input logic [31:0] pre, input logic [15:0] room, input logic [7:0] t2);
    preamble = pre; constant = 32'h0; thermostat_id = 32'hC0FF_EE01;
    room_temp = room; set_temp = 16'd200; state = 8'h5A;
    tail_1 = 8'hFF; tail_2 = t2; tail_3 = 8'hFF;
  endtask
  task automatic pulse_full;
    full = 1;
    step(1);
    full = 0;
  endtask
  initial begin
    set_frame(32'hAAAA_AAAA, 16'd215, 8'hFF);
    #12;
    check("rst_valid", out_valid, 0);
    check("rst_room", room_temp_out, 0);
    check("rst_ok", ok_count, 0);
    check("rst_err", err_count, 0);
    check("rst_drop", drop_count, 0);
    check("rst_lerr", last_error, 0);
    rst_n = 1;
    step(1);
    out_ready = 1;
    pulse_full;
    check("t1_check_nv", out_valid, 0);
    step(1);
    check("t1_valid", out_valid, 1);
    check("t1_room", room_temp_out, 215);
    check("t1_set", set_temp_out, 200);
    check("t1_state", state_out, 8'h5A);
    check("t1_id", thermostat_id_out, 32'hC0FF_EE01);
    check("t1_ok", ok_count, 1);
    step(1);
    check("t1_done", out_valid, 0);
    set_frame(32'hAAAA_AAAB, 16'd99, 8'hFF);
    pulse_full;
    step(1);
    check("t2_nv", out_valid, 0);
    check("t2_err", err_count, 1);
    check("t2_lerr", last_error, 1);
    check("t2_room_hold", room_temp_out, 215);
    check("t2_ok", ok_count, 1);
    step(1);
    out_ready = 0;
    set_frame(32'hAAAA_AAAA, 16'd300, 8'hFF);
    pulse_full;
    step(1);
    check("t3_valid", out_valid, 1);
    check("t3_room", room_temp_out, 300);
    check("t3_lerr", last_error, 0);
    set_frame(32'hAAAA_AAAA, 16'd777, 8'hFF);
    pulse_full;
    check("t3_drop", drop_count, 1);
    step(8);
    check("t3_hold_valid", out_valid, 1);
    check("t3_hold_room", room_temp_out, 300);
    out_ready = 1;
    step(1);
    check("t3_release", out_valid, 0);
    check("t3_readable", room_temp_out, 300);
    check("t3_ok", ok_count, 2);
    set_frame(32'hAAAA_AAAA, 16'd400, 8'hFE);
    pulse_full;
    step(1);
`ifdef FRAME_VALIDATOR_TAIL_CHECK_EN
    check("tail_err", err_count, 2);
    check("tail_ok", ok_count, 2);
`else
    check("tail_err", err_count, 1);
    check("tail_ok", ok_count, 3);
`endif
    step(1);
    out_ready = 0;
    set_frame(32'hAAAA_AAAA, 16'd500, 8'hFF);
    pulse_full;
    step(1);
    check("rp_valid", out_valid, 1);
    #2 rst_n = 0;
    full = 1;
    #1;
    check("rp_valid0", out_valid, 0);
    check("rp_room0", room_temp_out, 0);
    check("rp_ok0", ok_count, 0);
    check("rp_drop0", drop_count, 0);
    #2 rst_n = 1;
    step(1);
    full = 0;
    step(1);
    check("rel_strobe_valid", out_valid, 1);
    check("rel_strobe_ok", ok_count, 1);
    out_ready = 1;
    step(1);
    for (int i = 0; i < 300; i++) begin
      pulse_full;
      step(2);
    end
    check("sat_ok", ok_count, 255);
    out_ready = 0;
    pulse_full;
    step(1);
    for (int i = 0; i < 20; i++) begin
      pulse_full;
      step(1);
    end
    check("sat_drop", drop_count, 15);
    check("sat_hold_valid", out_valid, 1);
    check("sat_ok_hold", ok_count, 255);
    out_ready = 1;
    step(2);
    set_frame(32'h1234_5678, 16'd1, 8'hFF);
    full = 1;
    step(10);
    full = 0;
    step(1);
    check("held_full_err", err_count, 1);
    check("held_full_drop", drop_count, 15);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
